ram_word_packer: RTL and testbench

- Parametrised byte-to-word packer feeding the MU0 program/data RAM.
- Collects BYTES_PER_WORD bytes from a valid/ready byte stream and assembles them into one RAM word.
- Issues a one-cycle RAM write strobe for each word, at an auto-incrementing address.
- Supports a byte-order mode, partial-word flush with zero padding, and a full/overflow indication at the end of RAM.

---
 rtl/mu0_pkg.sv | 19 +
 rtl/ram_word_packer_byte_lane_shifter.sv | 41 ++++
 rtl/ram_word_packer.sv | 101 ++++++++++
 tb/tb_ram_word_packer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mu0_pkg.sv
// Shared MU0 constants and the packer state encoding.
package mu0_pkg;

  localparam int MU0_WORD_W = 16;
  localparam int MU0_ADDR_W = 12;
  localparam int MU0_DEPTH  = 4096;

  typedef enum logic [1:0] {
    COLLECT = 2'b00,
    WRITE   = 2'b01,
    FULL    = 2'b10
  } packer_state_t;

  // Byte k of a word lands in the top lane first when msb_first is set.
  function automatic int lane_of(input int idx, input int bytes_per_word, input bit msb_first);
    return msb_first ? (bytes_per_word - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/ram_word_packer_byte_lane_shifter.sv
// Word register and byte counter; places each loaded byte into its lane.
module byte_lane_shifter
  import mu0_pkg::*;
#(
  parameter int BYTE_W         = 8,
  parameter int BYTES_PER_WORD = 2,
  parameter int MSB_FIRST      = 1,
  parameter int WORD_W         = BYTE_W * BYTES_PER_WORD,
  parameter int CNT_W          = $clog2(BYTES_PER_WORD + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic [CNT_W-1:0]  count
);

  int lane;

  always_comb begin
    lane = lane_of(int'(count), BYTES_PER_WORD, MSB_FIRST != 0);
  end

  // Unwritten lanes stay zero, which gives flush its zero padding for free.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      word  <= '0;
      count <= '0;
    end else if (load) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (i == lane) begin
          word[i*BYTE_W +: BYTE_W] <= byte_in;
        end
      end
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ram_word_packer.sv
// Packs a valid/ready byte stream into RAM words with auto-incrementing address.
module ram_word_packer
  import mu0_pkg::*;
#(
  parameter int BYTE_W         = 8,
  parameter int BYTES_PER_WORD = 2,
  parameter int ADDR_W         = MU0_ADDR_W,
  parameter int DEPTH          = MU0_DEPTH,
  parameter int MSB_FIRST      = 1,
  parameter int WORD_W         = BYTE_W * BYTES_PER_WORD
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [WORD_W-1:0] word_data,
  output logic [ADDR_W-1:0] word_addr,
  output logic              word_we,
  output logic              full,
  output logic              overflow
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD + 1);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  packer_state_t    state;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             last_byte;
  logic             go_write;

  assign accept    = in_valid && in_ready;
  assign last_byte = (count == LAST_BYTE);
  // A flush shares the edge with a byte; the byte is stored before the write.
  assign go_write  = (accept && last_byte) || (flush && (accept || count != '0));

  byte_lane_shifter #(
    .BYTE_W         (BYTE_W),
    .BYTES_PER_WORD (BYTES_PER_WORD),
    .MSB_FIRST      (MSB_FIRST),
    .WORD_W         (WORD_W),
    .CNT_W          (CNT_W)
  ) u_shifter (
    .clock   (clock),
    .reset   (reset),
    .load    (accept),
    .clear   (state == WRITE),
    .byte_in (in_data),
    .word    (word_data),
    .count   (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= COLLECT;
      word_addr <= '0;
      word_we   <= 1'b0;
      full      <= 1'b0;
      overflow  <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      if (full && in_valid) begin
        overflow <= 1'b1;
      end
      case (state)
        COLLECT: begin
          if (go_write) begin
            state    <= WRITE;
            word_we  <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        WRITE: begin
          word_we <= 1'b0;
          if (word_addr == LAST_ADDR) begin
            state <= FULL;
            full  <= 1'b1;
          end else begin
            word_addr <= word_addr + ADDR_W'(1);
            state     <= COLLECT;
            in_ready  <= 1'b1;
          end
        end
        FULL: begin
          word_we  <= 1'b0;
          in_ready <= 1'b0;
          full     <= 1'b1;
        end
        default: begin
          state    <= COLLECT;
          word_we  <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_word_packer.sv
// Directed bench: default packer, an LSB-first copy and a 4-word copy share one stimulus.
module tb_ram_word_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        flush;
  logic [7:0]  in_data;

  logic        a_ready, a_we, a_full, a_overflow;
  logic [15:0] a_data;
  logic [11:0] a_addr;
  logic        b_ready, b_we, b_full, b_overflow;
  logic [15:0] b_data;
  logic [11:0] b_addr;
  logic        c_ready, c_we, c_full, c_overflow;
  logic [15:0] c_data;
  logic [11:0] c_addr;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  ram_word_packer dut_a (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_ready), .flush(flush), .word_data(a_data), .word_addr(a_addr),
    .word_we(a_we), .full(a_full), .overflow(a_overflow)
  );

  ram_word_packer #(.MSB_FIRST(0)) dut_b (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_ready), .flush(flush), .word_data(b_data), .word_addr(b_addr),
    .word_we(b_we), .full(b_full), .overflow(b_overflow)
  );

  ram_word_packer #(.DEPTH(4)) dut_c (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(c_ready), .flush(flush), .word_data(c_data), .word_addr(c_addr),
    .word_we(c_we), .full(c_full), .overflow(c_overflow)
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs; returns at the following falling edge.
  task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic f, input logic r);
    in_valid = v;
    in_data  = d;
    flush    = f;
    reset    = r;
    @(negedge clock);
  endtask

  initial begin
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_output("rst_ready", a_ready, 1);
    check_output("rst_we", a_we, 0);
    check_output("rst_addr", a_addr, 0);
    check_output("rst_data", a_data, 0);
    check_output("rst_full", a_full, 0);
    check_output("rst_overflow", a_overflow, 0);

    apply_stimulus(1'b1, 8'hA1, 1'b0, 1'b0);
    check_output("b0_we", a_we, 0);
    check_output("b0_ready", a_ready, 1);
    apply_stimulus(1'b1, 8'h23, 1'b0, 1'b0);
    check_output("w0_we", a_we, 1);
    check_output("w0_addr", a_addr, 0);
    check_output("w0_data", a_data, 16'hA123);
    check_output("w0_ready", a_ready, 0);
    check_output("lsb_w0_we", b_we, 1);
    check_output("lsb_w0_data", b_data, 16'h23A1);
    check_output("lsb_w0_addr", b_addr, 0);
    apply_stimulus(1'b1, 8'h45, 1'b0, 1'b0);
    check_output("w0_post_we", a_we, 0);
    check_output("w0_post_ready", a_ready, 1);
    check_output("w0_post_addr", a_addr, 1);
    apply_stimulus(1'b1, 8'h45, 1'b0, 1'b0);
    check_output("b2_we", a_we, 0);
    apply_stimulus(1'b1, 8'h67, 1'b0, 1'b0);
    check_output("w1_we", a_we, 1);
    check_output("w1_addr", a_addr, 1);
    check_output("w1_data", a_data, 16'h4567);
    check_output("w1_ready", a_ready, 0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_output("w1_post_ready", a_ready, 1);
    check_output("w1_post_addr", a_addr, 2);
    check_output("w1_post_we", a_we, 0);

    apply_stimulus(1'b1, 8'h5C, 1'b0, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("flush_we", a_we, 1);
    check_output("flush_addr", a_addr, 2);
    check_output("flush_data", a_data, 16'h5C00);
    check_output("lsb_flush_data", b_data, 16'h005C);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_output("flush_post_we", a_we, 0);
    check_output("flush_post_addr", a_addr, 3);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("flush_empty_we", a_we, 0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_output("flush_empty_we2", a_we, 0);
    check_output("flush_empty_addr", a_addr, 3);

    apply_stimulus(1'b1, 8'h11, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'h22, 1'b1, 1'b0);
    check_output("same_we", a_we, 1);
    check_output("same_addr", a_addr, 3);
    check_output("same_data", a_data, 16'h1122);
    check_output("d4_last_we", c_we, 1);
    check_output("d4_last_addr", c_addr, 3);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_output("same_post_we", a_we, 0);
    check_output("same_post_addr", a_addr, 4);
    check_output("d4_full", c_full, 1);
    check_output("d4_ready", c_ready, 0);
    check_output("d4_addr", c_addr, 3);
    check_output("d4_overflow_pre", c_overflow, 0);
    check_output("deep_not_full", a_full, 0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_output("same_no_extra_we", a_we, 0);

    apply_stimulus(1'b1, 8'h99, 1'b0, 1'b0);
    check_output("d4_overflow", c_overflow, 1);
    check_output("d4_ovf_we", c_we, 0);
    check_output("d4_ovf_full", c_full, 1);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("d4_overflow_sticky", c_overflow, 1);
    check_output("d4_flush_ignored_we", c_we, 0);
    check_output("d4_addr_hold", c_addr, 3);
    check_output("deep_no_overflow", a_overflow, 0);

    apply_stimulus(1'b1, 8'h77, 1'b0, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check_output("mid_rst_we", a_we, 0);
    check_output("mid_rst_addr", a_addr, 0);
    check_output("mid_rst_full", c_full, 0);
    check_output("mid_rst_overflow", c_overflow, 0);
    apply_stimulus(1'b1, 8'h0F, 1'b0, 1'b0);
    check_output("mid_rst_b0_we", a_we, 0);
    apply_stimulus(1'b1, 8'hF0, 1'b0, 1'b0);
    check_output("mid_rst_w_we", a_we, 1);
    check_output("mid_rst_w_addr", a_addr, 0);
    check_output("mid_rst_w_data", a_data, 16'h0FF0);
    check_output("lsb_mid_rst_data", b_data, 16'hF00F);
    check_output("d4_restart_we", c_we, 1);
    check_output("d4_restart_addr", c_addr, 0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_output("mid_rst_post_addr", a_addr, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
